bus_xfer_engine: RTL and testbench

- Parametrised successor to the mobo-level fixed RAM→VGA sequencer.
- Generic word-transfer master on the shared addr/data_in/data_out bus. It copies or fills a block of words between any of NDEV devices.
- Each device uses the ctrl/stat pin handshake: WRITE pin, READ pin, ACK.
- Adds start/done control, runtime length/base/device selection, fill mode, timeout and abort.

---
 rtl/bus_xfer_engine_pkg.sv | 29 ++
 rtl/bus_xfer_engine_timer.sv | 27 ++
 rtl/bus_xfer_engine.sv | 214 +++++++++++++++++++++
 tb/tb_bus_xfer_engine.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_xfer_engine_pkg.sv
// Shared definitions for the bus transfer engine: control/status pin
// positions (RAM/VGA compatible) and the sequencer state encoding.
package bus_xfer_engine_pkg;

  // Bit positions inside each 32-bit per-device control word
  localparam int WRITE_PIN = 0;
  localparam int READ_PIN  = 1;
  // Bit position inside each 32-bit per-device status word
  localparam int ACK       = 0;

  // state   | meaning
  // IDLE    | waiting for start, start checks done here
  // RD_REQ  | wait for source ACK low, then raise READ
  // RD_WAIT | READ high, wait for source ACK, capture data_in
  // WR_REQ  | wait for destination ACK low, then raise WRITE
  // WR_WAIT | WRITE high, wait for destination ACK
  // NEXT    | bump word count, decide next word or finish
  // DONE    | completion pulse
  // ERR     | timeout/abort pulse, pins already dropped
  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, DONE, ERR
  } xfer_state_t;

  // Control word with a single pin set
  function automatic logic [31:0] pin_mask(input int pin);
    pin_mask = 32'd1 << pin;
  endfunction

endpackage

// File: rtl/bus_xfer_engine_timer.sv
// Loadable down-counter used as the per-state handshake timeout.
// o_expire is high once the counter has run down to zero.
module xfer_handshake_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  // Reload on state entry, otherwise count down and hold at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/bus_xfer_engine.sv
// Word copy/fill master on the shared addr/data bus. Each word uses the
// four-phase READ/WRITE/ACK handshake of the selected device; a stalled
// handshake times out, and abort cancels the block. All outputs registered.
module bus_xfer_engine
  import bus_xfer_engine_pkg::*;
#(
  parameter int NDEV    = 2,
  parameter int SEL_W   = 1,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     src_dev,
  input  logic [SEL_W-1:0]     dst_dev,
  input  logic [31:0]          src_base,
  input  logic [31:0]          dst_base,
  input  logic [LEN_W-1:0]     len,
  input  logic [31:0]          fill_val,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LEN_W-1:0]     count,
  output logic [NDEV*32-1:0]   dev_ctrl,
  input  logic [NDEV*32-1:0]   dev_stat,
  output logic [31:0]          addr,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out
);

  // The timer is loaded with TIMEOUT-1 so that the state is left after
  // exactly TIMEOUT cycles without progress.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  xfer_state_t        r_state, w_state_nxt;
  logic               r_busy, r_done, r_err;
  logic               w_busy_nxt, w_done_nxt, w_err_nxt;
  logic [LEN_W-1:0]   r_count, w_count_nxt, w_count_inc;
  logic [NDEV*32-1:0] r_ctrl, w_ctrl_nxt;
  logic [31:0]        r_addr, w_addr_nxt, r_dout, w_dout_nxt, r_buf, w_buf_nxt;
  logic               w_accept, w_tmr_load, w_expire, w_tmo;
  logic               r_mode;
  logic [SEL_W-1:0]   r_src, r_dst;
  logic [31:0]        r_src_base, r_dst_base, r_fill;
  logic [LEN_W-1:0]   r_len;
  logic [2**SEL_W-1:0] w_ack;
  logic               w_src_ack, w_dst_ack, w_unused_stat;

  // ACK per select code; codes beyond NDEV read as idle
  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ack
    if (k < NDEV) begin : g_dev
      assign w_ack[k] = dev_stat[32*k+ACK];
    end else begin : g_pad
      assign w_ack[k] = 1'b0;
    end
  end

  assign w_src_ack     = w_ack[r_src];
  assign w_dst_ack     = w_ack[r_dst];
  assign w_unused_stat = ^dev_stat;
  assign w_count_inc   = r_count + LEN_W'(1);
  assign w_tmr_load    = (w_state_nxt != r_state);
  assign w_tmo         = (TIMEOUT != 0) && w_expire;

  xfer_handshake_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (TLOAD),
    .o_expire   (w_expire)
  );

  function automatic logic [NDEV*32-1:0] dev_pin(input logic [SEL_W-1:0] dev, input int pin);
    dev_pin = '0;
    for (int k = 0; k < NDEV; k++)
      if (int'(dev) == k) dev_pin[32*k +: 32] = pin_mask(pin);
  endfunction

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_count_nxt = r_count;
    w_ctrl_nxt  = r_ctrl;
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
    w_buf_nxt   = r_buf;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        if (int'(src_dev) >= NDEV || int'(dst_dev) >= NDEV) begin
          w_done_nxt = 1'b1;
          w_err_nxt  = 1'b1;
        end else if (len == '0) begin
          w_done_nxt = 1'b1;
          w_err_nxt  = 1'b0;
        end else begin
          w_accept    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_err_nxt   = 1'b0;
          w_count_nxt = '0;
          w_state_nxt = mode ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ: if (!w_src_ack) begin
        w_ctrl_nxt  = dev_pin(r_src, READ_PIN);
        w_addr_nxt  = r_src_base + 32'(r_count);
        w_state_nxt = RD_WAIT;
      end else if (w_tmo) w_state_nxt = ERR;
      RD_WAIT: if (w_src_ack) begin
        w_buf_nxt   = data_in;
        w_ctrl_nxt  = '0;
        w_state_nxt = WR_REQ;
      end else if (w_tmo) w_state_nxt = ERR;
      WR_REQ: if (!w_dst_ack) begin
        w_ctrl_nxt  = dev_pin(r_dst, WRITE_PIN);
        w_addr_nxt  = r_dst_base + 32'(r_count);
        w_dout_nxt  = r_mode ? r_fill : r_buf;
        w_state_nxt = WR_WAIT;
      end else if (w_tmo) w_state_nxt = ERR;
      WR_WAIT: if (w_dst_ack) begin
        w_ctrl_nxt  = '0;
        w_state_nxt = NEXT;
      end else if (w_tmo) w_state_nxt = ERR;
      NEXT: begin
        w_count_nxt = w_count_inc;
        if (w_count_inc == r_len) w_state_nxt = DONE;
        else                      w_state_nxt = r_mode ? WR_REQ : RD_REQ;
      end
      DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      ERR: begin
        w_ctrl_nxt  = '0;
        w_err_nxt   = 1'b1;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Abort beats any ACK seen this cycle; the word in flight is not counted
    if (abort && r_state != IDLE && r_state != ERR) begin
      w_state_nxt = ERR;
      w_count_nxt = r_count;
    end
    // Pins drop on the same edge that enters ERR
    if (w_state_nxt == ERR && r_state != ERR)
      w_ctrl_nxt = '0;
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
      r_ctrl  <= '0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_count <= w_count_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_addr  <= w_addr_nxt;
      r_dout  <= w_dout_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // Transfer parameters captured on an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= 1'b0;
      r_src      <= '0;
      r_dst      <= '0;
      r_src_base <= '0;
      r_dst_base <= '0;
      r_len      <= '0;
      r_fill     <= '0;
    end else if (w_accept) begin
      r_mode     <= mode;
      r_src      <= src_dev;
      r_dst      <= dst_dev;
      r_src_base <= src_base;
      r_dst_base <= dst_base;
      r_len      <= len;
      r_fill     <= fill_val;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign count    = r_count;
  assign dev_ctrl = r_ctrl;
  assign addr     = r_addr;
  assign data_out = r_dout;

endmodule

// File: tb/tb_bus_xfer_engine.sv
// Bench for bus_xfer_engine: behavioural device models on every channel,
// directed vector table, random transfers against a block-level model,
// and hand-written timeout / abort / reset sequences.
module tb_bus_xfer_engine;

  localparam int NDEV = 2, SEL_W = 2, LEN_W = 16, TIMEOUT = 8;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [SEL_W-1:0] src_dev = '0, dst_dev = '0;
  logic [31:0] src_base = '0, dst_base = '0, fill_val = '0, data_in = '0;
  logic [LEN_W-1:0] len = '0;
  logic busy, done, err;
  logic [LEN_W-1:0] count;
  logic [NDEV*32-1:0] dev_ctrl, dev_stat;
  logic [31:0] addr, data_out;

  bus_xfer_engine #(.NDEV(NDEV), .SEL_W(SEL_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .src_dev(src_dev), .dst_dev(dst_dev), .src_base(src_base), .dst_base(dst_base),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .err(err),
    .count(count), .dev_ctrl(dev_ctrl), .dev_stat(dev_stat), .addr(addr),
    .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    int          s, d;
    logic [31:0] sb, db;
    int          n;
    logic [31:0] fv;
    int          ls, ld;
    logic        e_err, e_acc;
  } vec_t;

  typedef struct {
    int          dev;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int checks = 0, errors = 0;
  int lat [NDEV];
  int hold [NDEV];
  logic [NDEV-1:0] ack = '0, prev_pin = '0;
  wr_t wlog[$];
  int n_reads, n_rd_cycles, n_pin_cycles, n_done, n_busy, n_viol = 0;
  int mcount = 0;

  assign dev_stat = {31'b0, ack[1], 31'b0, ack[0]};

  // Contents the devices return on a read
  function automatic logic [31:0] rd_data(input int k, input logic [31:0] a);
    logic [7:0] tag;
    if (k == 0 && a >= 32'h10 && a <= 32'h13) return 32'hA0 + (a - 32'h10);
    tag = 8'(k + 1);
    return (a * 32'h9E3779B1) ^ {tag, 24'h5A5A5A};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device models: ACK rises lat cycles after a request, drops after the pin
  always @(negedge clk) begin
    int active;
    logic wr, rd;
    active = 0;
    for (int k = 0; k < NDEV; k++) begin
      wr = dev_ctrl[32*k];
      rd = dev_ctrl[32*k+1];
      if (wr || rd) active++;
      if ((wr && rd) || ((wr || rd) && !prev_pin[k] && ack[k])) begin
        n_viol++;
        if (n_viol < 5) $display("FAIL protocol dev%0d: wr=%0b rd=%0b ack=%0b", k, wr, rd, ack[k]);
      end
      prev_pin[k] = wr | rd;
      if (rd) n_rd_cycles++;
      if (wr || rd) begin
        n_pin_cycles++;
        if (hold[k] >= lat[k] && !ack[k]) begin
          ack[k] = 1'b1;
          if (rd) begin
            data_in = rd_data(k, addr);
            n_reads++;
          end else wlog.push_back('{k, addr, data_out});
        end
        hold[k]++;
      end else begin
        ack[k]  = 1'b0;
        hold[k] = 0;
      end
    end
    if (active > 1) begin
      n_viol++;
      if (n_viol < 5) $display("FAIL protocol: %0d devices driven", active);
    end
    if (done) n_done++;
    if (busy) n_busy++;
  end

  task automatic kick(input vec_t v);
    @(negedge clk);
    if (v.s < NDEV) lat[v.s] = v.ls;
    if (v.d < NDEV) lat[v.d] = v.ld;
    mode = v.m; src_dev = SEL_W'(v.s); dst_dev = SEL_W'(v.d);
    src_base = v.sb; dst_base = v.db; len = LEN_W'(v.n); fill_val = v.fv;
    wlog.delete();
    n_reads = 0; n_rd_cycles = 0; n_pin_cycles = 0; n_done = 0; n_busy = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output logic got, output int waited);
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < 600; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      waited++;
      @(negedge clk);
    end
  endtask

  // Full transfer checked against the block-level model
  task automatic run(input vec_t v);
    logic got;
    int waited, exp_n;
    logic [31:0] exp_a, exp_d;
    kick(v);
    wait_done(got, waited);
    repeat (2) @(negedge clk);
    chk("done_seen", got, 1);
    chk("done_pulses", n_done, 1);
    chk("err", err, v.e_err);
    chk("busy_after", busy, 0);
    if (v.e_acc) mcount = v.n;
    chk("count", count, mcount);
    chk("busy_seen", n_busy > 0, v.e_acc);
    exp_n = v.e_acc ? v.n : 0;
    chk("n_writes", wlog.size(), exp_n);
    chk("n_reads", n_reads, (v.e_acc && !v.m) ? v.n : 0);
    if (v.m) chk("fill_no_read", n_rd_cycles, 0);
    if (!v.e_acc) begin
      chk("reject_latency", waited, 0);
      chk("reject_pins", n_pin_cycles, 0);
    end
    for (int i = 0; i < exp_n && i < wlog.size(); i++) begin
      exp_a = v.db + 32'(i);
      exp_d = v.m ? v.fv : rd_data(v.s, v.sb + 32'(i));
      chk("wr_dev", wlog[i].dev, v.d);
      chk("wr_addr", wlog[i].a, exp_a);
      chk("wr_data", wlog[i].d, exp_d);
    end
  endtask

  initial begin
    vec_t tbl [7];
    vec_t v;
    logic got;
    int waited;

    //              m     s  d  sb            db            n  fv            ls ld e_err e_acc
    tbl[0] = '{1'b0, 0, 1, 32'h10,       32'h200,      4, 32'h0,        3, 3, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 0, 0, 32'h0,        32'h0,        3, 32'h00000241, 0, 1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 0, 1, 32'h10,       32'h200,      0, 32'h0,        0, 0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 3, 1, 32'h10,       32'h200,      4, 32'h0,        0, 0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 0, 2, 32'h0,        32'h40,       2, 32'h77,       0, 0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1, 0, 32'h70,       32'hFFFFFFFE, 3, 32'h0,        1, 2, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1, 1, 32'h8,        32'h100,      2, 32'h0,        0, 0, 1'b0, 1'b1};

    for (int k = 0; k < NDEV; k++) begin
      lat[k]  = 0;
      hold[k] = 0;
    end

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {busy, done, err, count, addr, data_out}, 0);
    chk("reset_ctrl", dev_ctrl, 0);

    for (int i = 0; i < 7; i++) run(tbl[i]);

    // Random legal transfers
    for (int i = 0; i < 20; i++) begin
      v.m  = 1'($urandom_range(0, 1));
      v.s  = $urandom_range(0, 1);
      v.d  = $urandom_range(0, 1);
      v.sb = $urandom;
      v.db = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFD : $urandom;
      v.n  = $urandom_range(1, 6);
      v.fv = $urandom;
      v.ls = $urandom_range(0, 3);
      v.ld = $urandom_range(0, 3);
      v.e_err = 1'b0;
      v.e_acc = 1'b1;
      run(v);
    end

    // Timeout: destination never acknowledges
    v = '{1'b1, 0, 1, 32'h0, 32'h40, 2, 32'h1234, 0, 1000, 1'b1, 1'b1};
    kick(v);
    wait_done(got, waited);
    chk("tmo_done", got, 1);
    chk("tmo_err", err, 1);
    chk("tmo_count", count, 0);
    chk("tmo_write_cycles", n_pin_cycles, TIMEOUT);
    chk("tmo_ctrl", dev_ctrl, 0);
    chk("tmo_writes", wlog.size(), 0);
    repeat (2) @(negedge clk);
    chk("tmo_done_pulses", n_done, 1);

    // Next accepted start clears err
    v = '{1'b0, 1, 0, 32'h20, 32'h80, 2, 32'h0, 0, 1, 1'b0, 1'b1};
    kick(v);
    chk("err_cleared", err, 0);
    chk("busy_on_accept", busy, 1);
    wait_done(got, waited);
    repeat (2) @(negedge clk);
    chk("clr_done", got, 1);
    chk("clr_err", err, 0);
    chk("clr_count", count, 2);
    chk("clr_writes", wlog.size(), 2);

    // Abort during the second word's WAIT
    v = '{1'b1, 0, 1, 32'h0, 32'h300, 4, 32'hCAFE, 0, 5, 1'b1, 1'b1};
    kick(v);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wlog.size() == 1 && dev_ctrl[32] && !ack[1]) begin
        got = 1'b1;
        break;
      end
    end
    chk("abort_reached_word2", got, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ctrl", dev_ctrl, 0);
    wait_done(got, waited);
    chk("abort_done", got, 1);
    chk("abort_err", err, 1);
    chk("abort_count", count, 1);
    repeat (2) @(negedge clk);
    chk("abort_writes", wlog.size(), 1);
    chk("abort_done_pulses", n_done, 1);

    // Asynchronous reset while READ is held
    v = '{1'b0, 0, 1, 32'h50, 32'h600, 3, 32'h0, 5, 0, 1'b0, 1'b1};
    kick(v);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dev_ctrl[1]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_reached_rdwait", got, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_outputs", {busy, done, err, count, addr, data_out}, 0);
    chk("rst_async_ctrl", dev_ctrl, 0);
    @(negedge clk);
    rst = 1'b0;
    mcount = 0;
    run('{1'b0, 0, 1, 32'h11, 32'h700, 2, 32'h0, 1, 1, 1'b0, 1'b1});

    chk("protocol_violations", n_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
